// File: rtl/adat_frame_decoder.sv
// ADAT receiver: recovers bit timing from an oversampled NRZI line, locks to the
// zero-run sync and unpacks user bits plus eight 24-bit channels per frame.
module adat_frame_decoder #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int SYNC_ZEROS     = 10,
  parameter int LOSS_BITS      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adat_in,
  output logic [0:7][23:0] audio_out,
  output logic [3:0]       user_out,
  output logic             smux2,
  output logic             frame_valid,
  output logic             frame_error,
  output logic             locked
);

  localparam int HALF_BIT    = CLOCKS_PER_BIT / 2;
  localparam int PHASE_W     = $clog2(CLOCKS_PER_BIT);
  localparam int LOSS_CYCLES = LOSS_BITS * CLOCKS_PER_BIT;
  localparam int IDLE_W      = $clog2(LOSS_CYCLES + 1);
  localparam int DATA_BITS   = 196;

  localparam logic [PHASE_W-1:0] SAMPLE_PHASE = PHASE_W'(HALF_BIT - 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE   = PHASE_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LIMIT   = IDLE_W'(LOSS_CYCLES);
  localparam logic [3:0]         SYNC_MIN     = 4'(SYNC_ZEROS);
  localparam logic [7:0]         START_IDX    = 8'd245;
  localparam logic [7:0]         USER_SEP_IDX = 8'd240;

  typedef enum logic [0:0] {HUNT = 1'b0, DATA = 1'b1} state_t;

  logic                 sync1_r;
  logic                 sync2_r;
  logic                 prev_r;
  logic                 edge_s;
  logic [PHASE_W-1:0]   phase_r;
  logic                 edge_seen_r;
  logic                 sample_s;
  logic                 bit_s;
  logic [IDLE_W-1:0]    idle_r;
  logic                 loss_s;
  state_t               state_r;
  state_t               state_next_s;
  logic [3:0]           zero_run_r;
  logic [7:0]           bit_idx_r;
  logic [7:0]           cur_idx_s;
  logic                 is_sep_s;
  logic                 sync_hit_s;
  logic                 start_s;
  logic                 shift_s;
  logic                 done_s;
  logic                 err_s;
  logic [DATA_BITS-1:0] data_r;

  // Two-flop synchronizer plus the previous-level register used for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= adat_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // An edge landing on the sample phase re-centres the cell instead of sampling twice.
  assign edge_s     = sync2_r ^ prev_r;
  assign sample_s   = (phase_r == SAMPLE_PHASE) && !edge_s;
  assign bit_s      = edge_seen_r;
  assign loss_s     = (idle_r == IDLE_LIMIT);
  assign cur_idx_s  = bit_idx_r - 8'd1;
  assign is_sep_s   = (cur_idx_s == USER_SEP_IDX) ||
                      ((cur_idx_s < USER_SEP_IDX) && ((cur_idx_s % 8'd5) == 8'd0));
  assign sync_hit_s = sample_s && bit_s && (zero_run_r >= SYNC_MIN);

  // Bit-cell phase tracking, NRZI edge memory and line-idle timer
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r     <= '0;
      edge_seen_r <= 1'b0;
      idle_r      <= '0;
    end else begin
      if (edge_s || (phase_r == LAST_PHASE)) begin
        phase_r <= '0;
      end else begin
        phase_r <= phase_r + PHASE_W'(1);
      end
      if (edge_s) begin
        edge_seen_r <= 1'b1;
      end else if (sample_s) begin
        edge_seen_r <= 1'b0;
      end
      if (edge_s) begin
        idle_r <= '0;
      end else if (!loss_s) begin
        idle_r <= idle_r + IDLE_W'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      HUNT: begin
        if (sync_hit_s) begin
          state_next_s = DATA;
        end else begin
          state_next_s = HUNT;
        end
      end
      DATA: begin
        if (loss_s) begin
          state_next_s = HUNT;
        end else if (sample_s && is_sep_s && (!bit_s || (cur_idx_s == 8'd0))) begin
          state_next_s = HUNT;
        end else begin
          state_next_s = DATA;
        end
      end
      default: state_next_s = HUNT;
    endcase
  end

  // FSM output decode: frame start, data shift, completion and separator error
  always_comb begin
    start_s = 1'b0;
    shift_s = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      HUNT: start_s = sync_hit_s;
      DATA: begin
        if (sample_s && !loss_s) begin
          shift_s = !is_sep_s;
          err_s   = is_sep_s && !bit_s;
          done_s  = is_sep_s && bit_s && (cur_idx_s == 8'd0);
        end else begin
          shift_s = 1'b0;
          err_s   = 1'b0;
          done_s  = 1'b0;
        end
      end
      default: start_s = 1'b0;
    endcase
  end

  // Zero-run counter, frame bit index and data-bit holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_run_r <= 4'd0;
      bit_idx_r  <= 8'd0;
      data_r     <= '0;
    end else begin
      if ((state_r == HUNT) && sample_s) begin
        if (bit_s) begin
          zero_run_r <= 4'd0;
        end else if (zero_run_r != 4'd15) begin
          zero_run_r <= zero_run_r + 4'd1;
        end
      end
      if (start_s) begin
        bit_idx_r <= START_IDX;
      end else if ((state_r == DATA) && sample_s) begin
        bit_idx_r <= cur_idx_s;
      end
      if (shift_s) begin
        data_r <= {data_r[DATA_BITS-2:0], bit_s};
      end
    end
  end

  // Registered frame outputs; they hold the last good frame until the next one completes
  always_ff @(posedge clk) begin
    if (rst) begin
      audio_out   <= '0;
      user_out    <= 4'd0;
      smux2       <= 1'b0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      locked      <= 1'b0;
    end else begin
      frame_valid <= done_s;
      frame_error <= err_s;
      if (done_s) begin
        audio_out <= data_r[191:0];
        user_out  <= data_r[195:192];
        smux2     <= data_r[193];
      end
      if (done_s) begin
        locked <= 1'b1;
      end else if (err_s || loss_s) begin
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adat_frame_decoder.sv
// Scoreboard bench for adat_frame_decoder: an NRZI frame generator feeds the
// line while a forked monitor pops expected frames whenever a pulse appears.
module tb_adat_frame_decoder;

  localparam int CPB      = 8;
  localparam int LAT_MAX  = 2 + CPB / 2 + 1;
  localparam int LOSS_CYC = 16 * CPB;

  typedef struct {
    bit               err;
    logic [0:7][23:0] audio;
    logic [3:0]       user;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             adat_in;
  logic [0:7][23:0] audio_out;
  logic [3:0]       user_out;
  logic             smux2;
  logic             frame_valid;
  logic             frame_error;
  logic             locked;

  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               last_edge_cyc = 0;
  logic             line = 1'b0;
  exp_t             exp_q[$];
  logic [0:7][23:0] last_audio = '0;
  logic [3:0]       last_user = 4'd0;

  adat_frame_decoder #(.CLOCKS_PER_BIT(CPB), .SYNC_ZEROS(10), .LOSS_BITS(16)) dut (
    .clk(clk), .rst(rst), .adat_in(adat_in), .audio_out(audio_out), .user_out(user_out),
    .smux2(smux2), .frame_valid(frame_valid), .frame_error(frame_error), .locked(locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  // NRZI: a 1 toggles the line, a 0 holds it, for one bit cell
  task automatic send_bit(input bit b);
    if (b) begin
      line = ~line;
      last_edge_cyc = cyc;
    end
    adat_in = line;
    repeat (CPB) wait_clk();
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) wait_clk();
  endtask

  function automatic logic [0:7][23:0] rand_ch();
    logic [0:7][23:0] r;
    for (int c = 0; c < 8; c++) r[c] = 24'($urandom());
    return r;
  endfunction

  // Builds a whole frame from its fields; bad_ch >= 0 zeroes that channel's nibble-2
  // separator, cut_at >= 0 pulses rst at that bit and abandons the frame.
  task automatic send_frame(input logic [0:7][23:0] ch, input logic [3:0] u, input bit smux,
                            input int bad_ch, input int cut_at);
    bit   bits[$];
    exp_t e;
    logic [3:0] uu;
    uu = smux ? (u | 4'b0010) : u;
    for (int i = 0; i < 10; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    for (int i = 3; i >= 0; i--) bits.push_back(uu[i]);
    bits.push_back(1'b1);
    for (int c = 0; c < 8; c++) begin
      for (int n = 5; n >= 0; n--) begin
        for (int k = 3; k >= 0; k--) bits.push_back(ch[c][n*4+k]);
        bits.push_back(!((c == bad_ch) && (n == 2)));
      end
    end
    e.err = (bad_ch >= 0);
    e.audio = ch;
    e.user = uu;
    if (cut_at < 0) exp_q.push_back(e);
    foreach (bits[i]) begin
      if (i == cut_at) begin
        rst = 1'b1;
        wait_clk();
        rst = 1'b0;
        return;
      end
      send_bit(bits[i]);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0) && (n < 400)) begin
      wait_clk();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d frames without a pulse, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic monitor_step();
    exp_t e;
    int   lat;
    if (rst) begin
      last_audio = '0;
      last_user = 4'd0;
    end else if (frame_valid || frame_error) begin
      chk("pulse_exclusive", 192'(frame_valid & frame_error), 192'(1'b0));
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: valid=%0b error=%0b, required no pulse", frame_valid, frame_error);
      end else begin
        e = exp_q.pop_front();
        if (!e.err) begin
          chk("valid_kind", 192'(frame_valid), 192'(1'b1));
          chk("audio", audio_out, e.audio);
          chk("user", 192'(user_out), 192'(e.user));
          chk("smux2", 192'(smux2), 192'(e.user[1]));
          chk("locked_on_valid", 192'(locked), 192'(1'b1));
          lat = cyc - last_edge_cyc;
          total++;
          if (lat > LAT_MAX) begin
            bad++;
            $display("FAIL latency: got %0d cycles, required <= %0d", lat, LAT_MAX);
          end
          last_audio = e.audio;
          last_user = e.user;
        end else begin
          chk("error_kind", 192'(frame_error), 192'(1'b1));
          chk("hold_audio_on_error", audio_out, last_audio);
          chk("hold_user_on_error", 192'(user_out), 192'(last_user));
          chk("locked_on_error", 192'(locked), 192'(1'b0));
        end
      end
    end
  endtask

  initial begin
    logic [0:7][23:0] ch;
    int fall;
    rst = 1'b1;
    adat_in = 1'b0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset state
    repeat (5) wait_clk();
    rst = 1'b0;
    chk("rst_audio", audio_out, 192'd0);
    chk("rst_user", 192'(user_out), 192'd0);
    chk("rst_smux2", 192'(smux2), 192'd0);
    chk("rst_valid", 192'(frame_valid), 192'd0);
    chk("rst_error", 192'(frame_error), 192'd0);
    chk("rst_locked", 192'(locked), 192'd0);

    // Constant line: no pulses, no lock
    repeat (1000) wait_clk();
    chk("idle_locked", 192'(locked), 192'd0);

    // Fixed reference frame
    ch = {24'h123456, 24'hABCDEF, 24'h000001, 24'h800000,
          24'hFFFFFF, 24'h5A5A5A, 24'hA5A5A5, 24'h000000};
    send_frame(ch, 4'b1001, 1'b0, -1, -1);
    drain();

    // Three back-to-back frames, then idle until lock is lost
    for (int i = 0; i < 3; i++) send_frame(rand_ch(), 4'($urandom()), 1'b0, -1, -1);
    drain();
    fall = -1;
    for (int i = 0; i < 40 * CPB; i++) begin
      wait_clk();
      if ((fall < 0) && !locked) fall = cyc;
    end
    total++;
    if ((fall < 0) || (fall - last_edge_cyc < LOSS_CYC) || (fall - last_edge_cyc > LOSS_CYC + 8)) begin
      bad++;
      $display("FAIL loss_timing: locked fell %0d cycles after last edge, required %0d..%0d",
               (fall < 0) ? -1 : fall - last_edge_cyc, LOSS_CYC, LOSS_CYC + 8);
    end
    chk("hold_after_loss", audio_out, last_audio);

    // Broken separator, then a clean frame
    send_frame(rand_ch(), 4'($urandom()), 1'b0, 3, -1);
    send_frame(rand_ch(), 4'($urandom()), 1'b0, -1, -1);
    drain();
    chk("locked_after_recovery", 192'(locked), 192'(1'b1));

    // Reset mid-frame, then a clean frame
    send_frame(rand_ch(), 4'($urandom()), 1'b0, -1, 120);
    idle_bits(20);
    send_frame(rand_ch(), 4'($urandom()), 1'b0, -1, -1);
    drain();

    // S/MUX2 frame, then the same frame with the line polarity inverted
    ch = rand_ch();
    send_frame(ch, 4'b0000, 1'b1, -1, -1);
    drain();
    rst = 1'b1;
    line = ~line;
    adat_in = line;
    repeat (3) wait_clk();
    rst = 1'b0;
    idle_bits(20);
    send_frame(ch, 4'b0000, 1'b1, -1, -1);
    drain();

    // Random frames with random user bits and mode
    for (int i = 0; i < 4; i++) begin
      send_frame(rand_ch(), 4'($urandom()), 1'($urandom_range(0, 1)), -1, -1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
